gpio_bank: RTL and testbench

Parametrised memory-mapped GPIO peripheral replacing the fixed-width, output-only LED/PMOD/Arduino register blocks. It provides per-pin direction control, atomic set/clear writes, and synchronised, debounced inputs. Per-pin rising/falling-edge interrupt capture is combined into a single level `irq_out`. It sits on the shared peripheral memory bus and drives its read data onto the OR-combined read bus like every other peripheral.

---
 rtl/gpio_pkg.sv | 29 ++
 rtl/gpio_debounce.sv | 49 ++++
 rtl/gpio_bank.sv | 98 +++++++++
 tb/tb_gpio_bank.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank: register byte offsets and the
// word index decoded from address bits [4:2].
package gpio_pkg;

   localparam logic [7:0] GPIO_OUT        = 8'h00;
   localparam logic [7:0] GPIO_OE         = 8'h04;
   localparam logic [7:0] GPIO_IN         = 8'h08;
   localparam logic [7:0] GPIO_SET        = 8'h0C;
   localparam logic [7:0] GPIO_CLR        = 8'h10;
   localparam logic [7:0] GPIO_RISE_EN    = 8'h14;
   localparam logic [7:0] GPIO_FALL_EN    = 8'h18;
   localparam logic [7:0] GPIO_IRQ_STATUS = 8'h1C;

   typedef enum logic [2:0] {
      REG_OUT        = 3'd0,
      REG_OE         = 3'd1,
      REG_IN         = 3'd2,
      REG_SET        = 3'd3,
      REG_CLR        = 3'd4,
      REG_RISE_EN    = 3'd5,
      REG_FALL_EN    = 3'd6,
      REG_IRQ_STATUS = 3'd7
   } reg_idx_e;

   function automatic reg_idx_e reg_idx(input logic [31:0] addr);
      return reg_idx_e'(addr[4:2]);
   endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One pin of input conditioning: two-flop synchroniser, stability counter and
// debounced level, plus single-cycle pulses flagging the edge that flips it.
module gpio_debounce #(
   parameter int DEBOUNCE_CYCLES = 36000
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          s_q;
   logic [CW-1:0] c_q;
   logic          qual;

   // High in the cycle whose closing edge commits a new stable level, so the
   // IRQ capture lands on the same edge as the IN register update.
   assign qual   = (sync_q[1] != s_q) && (c_q == C_MAX);
   assign stable = s_q;
   assign rise   = qual &  sync_q[1];
   assign fall   = qual & ~sync_q[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         s_q    <= 1'b0;
         c_q    <= '0;
      end else begin
         sync_q <= {sync_q[0], pin};
         if (sync_q[1] != s_q) begin
            if (c_q == C_MAX) begin
               s_q <= sync_q[1];
               c_q <= '0;
            end else begin
               c_q <= c_q + CW'(1);
            end
         end else begin
            c_q <= '0;
         end
      end
   end

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: OUT/OE with atomic SET/CLR, debounced IN, and
// per-pin edge capture into a W1C status register that drives irq_out.
module gpio_bank
   import gpio_pkg::*;
#(
   parameter int               WIDTH           = 32,
   parameter int               DEBOUNCE_CYCLES = 36000,
   parameter logic [WIDTH-1:0] RESET_OUT       = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      address_in,
   input  logic             sel_in,
   input  logic             read_in,
   output logic [31:0]      read_value_out,
   input  logic [3:0]       write_mask_in,
   input  logic [31:0]      write_value_in,
   output logic             ready_out,
   input  logic [WIDTH-1:0] pins_in,
   output logic [WIDTH-1:0] pins_out,
   output logic [WIDTH-1:0] pins_oe,
   output logic             irq_out
);

   logic [WIDTH-1:0] out_q, oe_q, rise_en_q, fall_en_q, irq_q;
   logic [WIDTH-1:0] in_s, rise, fall;
   logic [WIDTH-1:0] wmask, wval, w1c, rd;
   logic             wr;
   reg_idx_e         idx;

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk    (clk),
         .reset  (reset),
         .pin    (pins_in[i]),
         .stable (in_s[i]),
         .rise   (rise[i]),
         .fall   (fall[i])
      );
   end

   always_comb begin
      wmask = '0;
      for (int i = 0; i < WIDTH; i++) wmask[i] = write_mask_in[i/8];
   end

   assign idx  = reg_idx(address_in);
   assign wr   = sel_in & (|write_mask_in);
   assign wval = write_value_in[WIDTH-1:0] & wmask;
   assign w1c  = (wr && idx == REG_IRQ_STATUS) ? wval : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q     <= RESET_OUT;
         oe_q      <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         irq_q     <= '0;
      end else begin
         if (wr) begin
            case (idx)
               REG_OUT:     out_q     <= (out_q & ~wmask) | wval;
               REG_OE:      oe_q      <= (oe_q & ~wmask) | wval;
               REG_SET:     out_q     <= out_q | wval;
               REG_CLR:     out_q     <= out_q & ~wval;
               REG_RISE_EN: rise_en_q <= (rise_en_q & ~wmask) | wval;
               REG_FALL_EN: fall_en_q <= (fall_en_q & ~wmask) | wval;
               default: ;
            endcase
         end
         // An edge arriving on the same edge as a W1C keeps the bit set.
         irq_q <= (irq_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
      end
   end

   always_comb begin
      rd = '0;
      case (idx)
         REG_OUT:        rd = out_q;
         REG_OE:         rd = oe_q;
         REG_IN:         rd = in_s;
         REG_RISE_EN:    rd = rise_en_q;
         REG_FALL_EN:    rd = fall_en_q;
         REG_IRQ_STATUS: rd = irq_q;
         default:        rd = '0;
      endcase
   end

   assign read_value_out = (sel_in && !reset) ? 32'(rd) : 32'd0;
   assign ready_out      = sel_in;
   assign pins_out       = out_q;
   assign pins_oe        = oe_q;
   assign irq_out        = (|irq_q) & ~reset;

   logic unused_bits;
   assign unused_bits = ^{read_in, address_in[31:5], address_in[1:0], write_value_in};

endmodule

// File: tb/tb_gpio_bank.sv
// Randomised and directed bench for gpio_bank (WIDTH=8, DEBOUNCE_CYCLES=4):
// driver pushes expectations from a run-length reference model, monitor pops and compares.
module tb_gpio_bank;

   localparam int         W  = 8;
   localparam int         D  = 4;
   localparam logic [7:0] RO = 8'hA5;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] address_in;
   logic        sel_in, read_in;
   logic [31:0] read_value_out;
   logic [3:0]  write_mask_in;
   logic [31:0] write_value_in;
   logic        ready_out;
   logic [W-1:0] pins_in, pins_out, pins_oe;
   logic        irq_out;

   gpio_bank #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .RESET_OUT(RO)) dut (
      .clk(clk), .reset(reset), .address_in(address_in), .sel_in(sel_in),
      .read_in(read_in), .read_value_out(read_value_out),
      .write_mask_in(write_mask_in), .write_value_in(write_value_in),
      .ready_out(ready_out), .pins_in(pins_in), .pins_out(pins_out),
      .pins_oe(pins_oe), .irq_out(irq_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] rd;
      logic [7:0]  po, oe;
      logic        irq, rdy;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: registers plus a history of raw pin samples.
   logic [7:0] m_out, m_oe, m_ren, m_fen, m_irq, m_s;
   logic [7:0] samp [0:D];

   function automatic logic [31:0] mread(input logic [31:0] a);
      case (a[4:2])
         3'd0:    return {24'b0, m_out};
         3'd1:    return {24'b0, m_oe};
         3'd2:    return {24'b0, m_s};
         3'd5:    return {24'b0, m_ren};
         3'd6:    return {24'b0, m_fen};
         3'd7:    return {24'b0, m_irq};
         default: return 32'd0;
      endcase
   endfunction

   // A pin's stable level flips once its last D synchronised samples all disagree with it.
   task automatic step();
      logic [7:0] flip, new_s, bm, v, clr, ren0, fen0;
      if (reset) begin
         m_out = RO; m_oe = 0; m_ren = 0; m_fen = 0; m_irq = 0; m_s = 0;
         for (int k = 0; k <= D; k++) samp[k] = 8'h00;
      end else begin
         for (int i = 0; i < W; i++) begin
            flip[i] = 1'b1;
            for (int k = 1; k <= D; k++) if (samp[k][i] == m_s[i]) flip[i] = 1'b0;
         end
         new_s = m_s ^ flip;
         ren0 = m_ren; fen0 = m_fen; clr = 0;
         bm = write_mask_in[0] ? 8'hFF : 8'h00;
         v  = write_value_in[7:0] & bm;
         if (sel_in && write_mask_in != 0) begin
            case (address_in[4:2])
               3'd0: m_out = (m_out & ~bm) | v;
               3'd1: m_oe  = (m_oe & ~bm) | v;
               3'd3: m_out = m_out | v;
               3'd4: m_out = m_out & ~v;
               3'd5: m_ren = (m_ren & ~bm) | v;
               3'd6: m_fen = (m_fen & ~bm) | v;
               3'd7: clr = v;
               default: ;
            endcase
         end
         m_irq = (m_irq & ~clr) | (flip & new_s & ren0) | (flip & ~new_s & fen0);
         m_s = new_s;
         for (int k = D; k > 0; k--) samp[k] = samp[k-1];
         samp[0] = pins_in;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input string nm, input bit s, input bit r, input logic [31:0] a,
                      input logic [3:0] m, input logic [31:0] d);
      exp_t e;
      sel_in = s; read_in = r; address_in = a; write_mask_in = m; write_value_in = d;
      if (r) begin
         e.name = nm;
         e.rd   = (s && !reset) ? mread(a) : 32'd0;
         e.po   = m_out;
         e.oe   = m_oe;
         e.irq  = (|m_irq) && !reset;
         e.rdy  = s;
         exp_q.push_back(e);
      end
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus("idle", 0, 0, 0, 0, 0);
   endtask
   task automatic rd(input string nm, input logic [31:0] a); bus(nm, 1, 1, a, 4'h0, 0); endtask
   task automatic wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
      bus("wr", 1, 0, a, m, d);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (read_in) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_underflow got read with no expectation want queued entry");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".rdata"}, read_value_out, e.rd);
            chk({e.name, ".pins_out"}, {24'b0, pins_out}, {24'b0, e.po});
            chk({e.name, ".pins_oe"}, {24'b0, pins_oe}, {24'b0, e.oe});
            chk({e.name, ".irq_out"}, {31'b0, irq_out}, {31'b0, e.irq});
            chk({e.name, ".ready"}, {31'b0, ready_out}, {31'b0, e.rdy});
         end
      end
   end

   initial begin
      reset = 1'b1; pins_in = 8'h00;
      sel_in = 0; read_in = 0; address_in = 0; write_mask_in = 0; write_value_in = 0;
      idle(2);
      rd("rst_read", 32'h1C);
      rd("rst_read_out", 32'h00);
      reset = 1'b0;
      for (int a = 0; a < 8; a++) rd("reset_vals", 32'(a * 4));

      // OUT/SET/CLR with a masked-off write in between
      wr(32'h00, 4'hF, 32'h0F);
      wr(32'h0C, 4'hF, 32'h30);
      wr(32'h10, 4'hF, 32'h01);
      wr(32'h00, 4'h0, 32'hFF);
      rd("out_set_clr", 32'h00);
      wr(32'h0C, 4'hF, 32'h40);
      wr(32'h0C, 4'hF, 32'h40);
      rd("set_repeat", 32'h00);
      wr(32'h04, 4'h1, 32'hC3);
      rd("oe", 32'h04);

      // Debounce timing on pin 2, then a short glitch on pin 3
      wr(32'h14, 4'hF, 32'h04);
      pins_in[2] = 1'b1;
      for (int i = 0; i < 8; i++) rd("db_rise_in", 32'h08);
      rd("irq_rise", 32'h1C);
      wr(32'h1C, 4'hF, 32'h04);
      rd("w1c", 32'h1C);
      pins_in[3] = 1'b1;
      idle(2);
      pins_in[3] = 1'b0;
      for (int i = 0; i < 8; i++) rd("glitch", 32'h08);

      // Falling edge with FALL_EN clear sets nothing
      pins_in[2] = 1'b0;
      for (int i = 0; i < 8; i++) rd("fall_noen", 32'h1C);

      // W1C on the very edge a new rise on pin 2 qualifies
      pins_in[2] = 1'b1;
      idle(D + 1);
      wr(32'h1C, 4'hF, 32'h04);
      rd("w1c_vs_edge", 32'h1C);
      rd("w1c_vs_edge_in", 32'h08);

      // Fill IRQ_STATUS, then reset in the middle of a debounce
      wr(32'h14, 4'hF, 32'hFF);
      wr(32'h18, 4'hF, 32'hFF);
      pins_in = ~pins_in;
      idle(D + 3);
      rd("irq_all", 32'h1C);
      pins_in[0] = ~pins_in[0];
      idle(4);
      reset = 1'b1;
      rd("rst_mid", 32'h08);
      idle(1);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) rd("post_rst_in", 32'h08);
      rd("post_rst_irq", 32'h1C);

      // Randomised traffic
      for (int n = 0; n < 600; n++) begin
         int op;
         if ($urandom_range(0, 5) == 0) pins_in[$urandom_range(0, 7)] ^= 1'b1;
         op = $urandom_range(0, 9);
         if (op < 4)      rd("rnd_rd", {$urandom} & 32'h1C);
         else if (op < 7) wr({$urandom} & 32'h1C, 4'($urandom), $urandom);
         else if (op < 8) bus("rnd_nosel", 0, 1, {$urandom} & 32'h1C, 0, 0);
         else if (op < 9) wr(32'h1C, 4'($urandom), $urandom);
         else             idle(1);
      end
      rd("final_irq", 32'h1C);
      idle(2);
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
